// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [31:0] OFFSET_DEF = 32'h0100_0000;
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;
endpackage

// File: rtl/mem_arb_merge.sv
// mem_arb_merge: sub-word store merge and load extension on the low byte lanes.
module mem_arb_merge
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] rd,
    input  logic [31:0] wd,
    output logic [31:0] merged,
    output logic [31:0] ext
);
    always_comb begin
        merged = size == SZ_BYTE ? {rd[31:8], wd[7:0]} :
                 size == SZ_HALF ? {rd[31:16], wd[15:0]} : wd;
        ext    = size == SZ_BYTE ? {{24{~uns & rd[7]}}, rd[7:0]} :
                 size == SZ_HALF ? {{16{~uns & rd[15]}}, rd[15:0]} : rd;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-addressed memory port between fetch and load/store.
// Define MEM_ARB_ALIGN_CHECK_EN to turn misaligned accesses into error responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] OFFSET       = OFFSET_DEF,
    parameter int          MEM_DEPTH    = 1048576,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic        dm_unsigned,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out
);
    localparam logic [3:0]  LIM = 4'(STARVE_LIMIT);
    localparam logic [31:0] TOP = 32'(MEM_DEPTH - 4);

    state_t state, next;
    logic        id_q, we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rmw_q;
    logic [3:0]  starve_cnt;
    logic        pick_if, grant, sel_word, sel_we, mis, g_err, resp;
    logic [31:0] sel_addr, rel, merged, ext;

    always_comb begin
        pick_if  = if_req & (~dm_req | starve_cnt == LIM);
        grant    = state == IDLE & (if_req | dm_req);
        sel_addr = pick_if ? if_addr : dm_addr;
        sel_word = pick_if | dm_size[1];
        sel_we   = ~pick_if & dm_we;
        rel      = sel_addr - OFFSET;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        mis      = sel_word ? |sel_addr[1:0] : dm_size == SZ_HALF & sel_addr[0];
`else
        mis      = 1'b0;
`endif
        g_err    = sel_addr < OFFSET | rel > TOP | mis;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = grant ? (g_err ? RESP : sel_we & ~sel_word ? RMW_RD : ACCESS) : IDLE;
            ACCESS:  next = RESP;
            RMW_RD:  next = RMW_WR;
            RMW_WR:  next = RESP;
            default: next = IDLE;
        endcase
    end

    // The read word feeds load extension in ACCESS and the merge source in RMW_WR.
    mem_arb_merge u_merge (
        .size   (size_q),
        .uns    (uns_q),
        .rd     (state == RMW_WR ? rmw_q : mem_data_out),
        .wd     (wdata_q),
        .merged (merged),
        .ext    (ext)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            id_q       <= REQ_IF;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= SZ_WORD;
            addr_q     <= OFFSET;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rmw_q      <= '0;
            starve_cnt <= '0;
        end else begin
            state <= next;
            if (grant) begin
                id_q    <= pick_if ? REQ_IF : REQ_DM;
                we_q    <= sel_we;
                uns_q   <= dm_unsigned;
                err_q   <= g_err;
                size_q  <= pick_if ? SZ_WORD : dm_size;
                wdata_q <= dm_wdata;
                rdata_q <= '0;
                if (!g_err) addr_q <= sel_addr;
                if (pick_if) starve_cnt <= '0;
                else if (if_req && starve_cnt != LIM) starve_cnt <= starve_cnt + 4'd1;
            end
            if (state == ACCESS) rdata_q <= we_q ? '0 : ext;
            if (state == RMW_RD) rmw_q <= mem_data_out;
        end
    end

    always_comb begin
        resp           = state == RESP;
        if_ack         = resp & id_q == REQ_IF;
        dm_ack         = resp & id_q == REQ_DM;
        if_rdata       = if_ack ? rdata_q : '0;
        dm_rdata       = dm_ack ? rdata_q : '0;
        if_err         = if_ack & err_q;
        dm_err         = dm_ack & err_q;
        mem_address    = addr_q;
        mem_read_write = (state == ACCESS & we_q) | state == RMW_WR;
        mem_data_in    = mem_read_write ? merged : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus starvation and mid-RMW reset sequences.
module tb_mem_port_arbiter;
    localparam logic [31:0] OFF = 32'h0100_0000;
    localparam int DEPTH = 1048576;

    logic clock = 1'b0, reset = 1'b0;
    logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dm_unsigned = 1'b0;
    logic [1:0] dm_size = 2'd2;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic if_ack, if_err, dm_ack, dm_err, mem_read_write;
    logic [31:0] if_rdata, dm_rdata, mem_address, mem_data_in, mem_data_out;

    logic [7:0] mem [DEPTH];
    int wr_cnt = 0;
    logic pk_en = 1'b0;
    logic [31:0] pk_addr = '0, pk_word = '0;
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
    );

    always_comb begin
        automatic int unsigned i = mem_address - OFF;
        mem_data_out = (mem_address >= OFF && i <= DEPTH - 4) ?
            {mem[i + 3], mem[i + 2], mem[i + 1], mem[i]} : 32'h0;
    end

    always @(posedge clock) begin
        automatic int unsigned i = mem_read_write ? mem_address - OFF : pk_addr - OFF;
        if (mem_read_write || pk_en) begin
            automatic logic [31:0] w = mem_read_write ? mem_data_in : pk_word;
            if (mem_read_write) wr_cnt++;
            if (i <= DEPTH - 4) {mem[i + 3], mem[i + 2], mem[i + 1], mem[i]} <= w;
        end
    end

    function automatic logic [31:0] peek(input logic [31:0] a);
        automatic int unsigned i = a - OFF;
        return {mem[i + 3], mem[i + 2], mem[i + 1], mem[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        @(negedge clock);
        pk_en = 1'b1; pk_addr = a; pk_word = w;
        @(negedge clock);
        pk_en = 1'b0;
    endtask

    task automatic do_req(input bit f, input bit we, input logic [1:0] sz, input bit u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output int lat, output int wr);
        int w0, n;
        @(negedge clock);
        if (f) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            dm_req = 1'b1; dm_we = we; dm_size = sz; dm_unsigned = u; dm_addr = a; dm_wdata = wd;
        end
        w0 = wr_cnt;
        @(posedge clock); #1;
        n = 1;
        while (!(f ? if_ack : dm_ack) && n < 8) begin
            @(posedge clock); #1;
            n++;
        end
        rd  = f ? if_rdata : dm_rdata;
        er  = f ? if_err : dm_err;
        lat = n;
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clock); #1;
        wr = wr_cnt - w0;
    endtask

    typedef struct {
        bit          f;
        bit          we;
        logic [1:0]  sz;
        bit          u;
        logic [31:0] a;
        logic [31:0] wd;
        bit          pre;
        logic [31:0] pw;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t v[16];
        logic [31:0] rd;
        bit er;
        int lat, wr, k;
        string exp_s, got_s;
        bit ack_seen;

        v[0]  = '{1, 0, 2'd2, 0, 32'h0100_0000, 32'h0,         1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 2};
        v[1]  = '{0, 1, 2'd0, 0, 32'h0100_0001, 32'h0000_00AA, 1, 32'h1122_3344, 32'h0,         0, 3};
        v[2]  = '{0, 0, 2'd2, 0, 32'h0100_0001, 32'h0,         0, 32'h0,         32'h1122_33AA, 0, 2};
        v[3]  = '{0, 0, 2'd0, 0, 32'h0100_0010, 32'h0,         1, 32'h0000_0080, 32'hFFFF_FF80, 0, 2};
        v[4]  = '{0, 0, 2'd0, 1, 32'h0100_0010, 32'h0,         0, 32'h0,         32'h0000_0080, 0, 2};
        v[5]  = '{0, 0, 2'd1, 0, 32'h0100_0020, 32'h0,         1, 32'h0000_8001, 32'hFFFF_8001, 0, 2};
        v[6]  = '{0, 0, 2'd1, 1, 32'h0100_0020, 32'h0,         0, 32'h0,         32'h0000_8001, 0, 2};
        v[7]  = '{0, 1, 2'd1, 0, 32'h0100_0030, 32'h1234_BEEF, 1, 32'hAABB_CCDD, 32'h0,         0, 3};
        v[8]  = '{0, 0, 2'd2, 0, 32'h0100_0030, 32'h0,         0, 32'h0,         32'hAABB_BEEF, 0, 2};
        v[9]  = '{0, 1, 2'd3, 0, 32'h0100_0040, 32'h1234_5678, 0, 32'h0,         32'h0,         0, 2};
        v[10] = '{0, 0, 2'd2, 0, 32'h0100_0040, 32'h0,         0, 32'h0,         32'h1234_5678, 0, 2};
        v[11] = '{0, 0, 2'd2, 0, 32'h00FF_FFFC, 32'h0,         0, 32'h0,         32'h0,         1, 1};
        v[12] = '{0, 0, 2'd2, 0, 32'h010F_FFFD, 32'h0,         0, 32'h0,         32'h0,         1, 1};
        v[13] = '{0, 1, 2'd2, 0, 32'h010F_FFFD, 32'h5555_5555, 0, 32'h0,         32'h0,         1, 1};
        v[14] = '{0, 0, 2'd2, 0, 32'h010F_FFFC, 32'h0,         1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 2};
        v[15] = '{1, 0, 2'd2, 0, 32'h0200_0000, 32'h0,         0, 32'h0,         32'h0,         1, 1};

        repeat (2) @(posedge clock);
        #1;
        check("rst_if_ack", 32'(if_ack), 0);
        check("rst_dm_ack", 32'(dm_ack), 0);
        check("rst_rw", 32'(mem_read_write), 0);
        check("rst_addr", mem_address, OFF);
        check("rst_data_in", mem_data_in, 0);
        check("rst_rdata", if_rdata | dm_rdata, 0);
        @(negedge clock);
        reset = 1'b1;

        poke(32'h0100_0005, 32'h0000_0055);
        for (int i = 0; i < 16; i++) begin
            if (v[i].pre) poke(v[i].a, v[i].pw);
            do_req(v[i].f, v[i].we, v[i].sz, v[i].u, v[i].a, v[i].wd, rd, er, lat, wr);
            check($sformatf("v%0d_rdata", i), rd, v[i].exp_rd);
            check($sformatf("v%0d_err", i), 32'(er), 32'(v[i].exp_err));
            check($sformatf("v%0d_lat", i), lat, v[i].exp_lat);
            check($sformatf("v%0d_writes", i), wr, (v[i].we && !v[i].exp_err) ? 1 : 0);
        end
        check("byte0_kept", 32'(mem[0]), 32'hEF);
        check("byte5_kept", 32'(mem[5]), 32'h55);

        exp_s = "DDDDIDDDDI";
        got_s = "";
        @(negedge clock);
        if_req = 1'b1; if_addr = OFF;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd2; dm_unsigned = 1'b0; dm_addr = 32'h0100_0010;
        k = 0;
        for (int c = 0; c < 200 && k < 10; c++) begin
            @(posedge clock); #1;
            if (if_ack) begin got_s = {got_s, "I"}; k++; end
            if (dm_ack) begin got_s = {got_s, "D"}; k++; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clock); #1;
        check("starve_count", k, 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("grant%0d", i), 32'(i < got_s.len() ? got_s[i] : 8'h3F), 32'(exp_s[i]));

        poke(32'h0100_0050, 32'h0102_0304);
        @(negedge clock);
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'd0; dm_addr = 32'h0100_0050; dm_wdata = 32'h0000_00FF;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("rmw_wr_active", 32'(mem_read_write), 1);
        reset = 1'b0;
        #1;
        check("rst_rw_drop", 32'(mem_read_write), 0);
        dm_req = 1'b0;
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            ack_seen |= dm_ack | if_ack;
        end
        check("rst_no_ack", 32'(ack_seen), 0);
        check("rst_word_kept", peek(32'h0100_0050), 32'h0102_0304);
        check("rst_addr2", mem_address, OFF);
        @(negedge clock);
        reset = 1'b1;
        do_req(0, 0, 2'd2, 0, 32'h0100_0050, 32'h0, rd, er, lat, wr);
        check("post_rst_rdata", rd, 32'h0102_0304);
        check("post_rst_lat", lat, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences a single shared byte-addressed memory port (address, data_in, read_write, data_out) between an instruction-fetch requester and a load/store requester. Arbitrates with data priority plus a fetch anti-starvation limit. Range-checks addresses against the memory window. Performs sub-word stores as read-modify-write, because the memory port always writes 4 bytes. Sits between the core's fetch/LSU stages and the memory instance.

Parameters:
OFFSET, 32'h01000000, base byte address of the memory window
MEM_DEPTH, 1048576, memory size in bytes
STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced to win (1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  32  fetch byte address; word read
if_ack  out  1  one-cycle pulse: response valid
if_rdata  out  32  fetched word; valid with if_ack
if_err  out  1  out-of-range or misaligned; valid with if_ack
dm_req  in  1  data request; held high until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
dm_unsigned  in  1  load zero-extends when 1, sign-extends when 0
dm_addr  in  32  data byte address
dm_wdata  in  32  store data, low bytes used for sub-word
dm_ack  out  1  one-cycle completion pulse
dm_rdata  out  32  extended load data; valid with dm_ack; 0 for stores and errors
dm_err  out  1  error flag; valid with dm_ack
mem_address  out  32  to memory address
mem_data_in  out  32  to memory data_in
mem_read_write  out  1  to memory read_write (1 = write at the next clock edge)
mem_data_out  in  32  from memory data_out (combinational read)

Behaviour:
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- Reset: state IDLE. All acks, errs and rdata are 0. mem_read_write is 0. mem_address is OFFSET. mem_data_in is 0. Starve counter is 0.
- Reset mid-operation: the in-flight request is dropped with no ack. mem_read_write falls immediately (asynchronously).
- IDLE: requests are sampled each cycle.
  - If only one requester is active, it wins.
  - If both are active, data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - starve_cnt increments (saturating) on each data grant while if_req is high. It clears on a fetch grant.
  - On grant, op/addr/size/wdata/unsigned are latched at the edge. Requesters need not hold them afterwards.
- Range check on the latched address: a = addr - OFFSET. Error if addr < OFFSET or a > MEM_DEPTH-4. Size is ignored for the range check.
  - On error: IDLE -> RESP, no memory access, rdata = 0, err = 1.
- Load or fetch: IDLE -> ACCESS -> RESP.
  - ACCESS drives mem_address = addr with mem_read_write = 0.
  - The byte/half is extracted from the low bytes of mem_data_out and extended per dm_unsigned.
- Word store: IDLE -> ACCESS -> RESP. ACCESS drives mem_read_write = 1 and mem_data_in = wdata.
- Byte/half store: IDLE -> RMW_RD -> RMW_WR -> RESP.
  - RMW_RD reads the word at addr and registers it.
  - RMW_WR writes the merged word back to addr:
    - Byte store: bits [7:0] from wdata, upper 24 bits from the read.
    - Half store: bits [15:0] from wdata, upper 16 bits from the read.
  - Any byte alignment is valid because the memory is byte-indexed.
- RESP: exactly one ack, to the granted requester, for one cycle. Next state is IDLE.
- Latency, counted as cycles after the grant edge until ack is high:
  - Error: 1
  - Load / fetch / word store: 2
  - Sub-word store: 3
- Outside a write cycle: mem_read_write = 0 and mem_data_in = 0. mem_address holds its last value, or OFFSET after reset.
- No pipelining: at most one outstanding access.

Optional Feature:
MEM_ARB_ALIGN_CHECK_EN:
- Defined: a misaligned access is an error response with no memory access.
  - Misaligned means a word (fetch, or dm_size 2/3) with addr[1:0] != 0, or a half with addr[0] != 0.
  - The error is detected in IDLE, latency 1.
- Undefined: any alignment is performed as specified above.

Decomposition:
- Package mem_arb_pkg:
  - State enum.
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - OFFSET default.
  - Requester id constants REQ_IF/REQ_DM.
- Sub-module mem_arb_merge (combinational). Inputs: size, unsigned, offset-free byte lanes. It performs both store merge and load extension.

Test Plan:
1. Memory preloaded at 0x01000000 = 0xDEADBEEF. if_req with if_addr 0x01000000 -> if_ack 2 cycles after grant, if_rdata 0xDEADBEEF, if_err 0.
2. Byte store dm_addr 0x01000001, wdata 0x000000AA over a word of 0x11223344 at 0x01000001 -> 3-cycle ack. Word at 0x01000001 then reads 0x112233AA; bytes outside that word are unchanged.
3. Load byte 0x80, signed -> dm_rdata 0xFFFFFF80. Same load with dm_unsigned=1 -> 0x00000080.
4. dm_addr 0x00FFFFFC, and dm_addr 0x01000000+MEM_DEPTH-3 -> dm_err=1 at latency 1, mem_read_write never asserted.
5. if_req and dm_req held continuously -> grant order is D,D,D,D,I,D,D,D,D,I for STARVE_LIMIT=4.
6. Reset asserted during RMW_WR -> no ack, mem_read_write low at once; after release, state IDLE and the memory word is unchanged.
